// File: rtl/sprite_plotter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_plotter
// Purpose  : Rasterises one press/garbage sprite request into per-pixel
//            vga_adapter writes (x, y, colour, plot) with a req/busy/done
//            handshake.
// Revision : 1.0  initial release
// ============================================================================
module sprite_plotter #(
  parameter int X0         = 20,
  parameter int LANE_PITCH = 32,
  parameter int PRESS_Y    = 40,
  parameter int GARB_Y     = 90,
  parameter int PRESS_W    = 16,
  parameter int PRESS_H    = 12,
  parameter int GARB_W     = 12,
  parameter int GARB_H     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       item,
  input  logic       erase,
  input  logic [2:0] position,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLOT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [8:0] C_X_LIMIT = 9'd160;
  localparam logic [8:0] C_Y_LIMIT = 9'd120;

  logic [1:0] state_q, state_d;
  logic       item_q, erase_q, fail_q;
  logic [2:0] pos_q;
  logic [8:0] ox_q, oy_q;
  logic [4:0] wm1_q, hm1_q, col_q, row_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q, err_q;

  logic [1:0] w_lane;
  logic       w_reject;
  logic [8:0] w_x_sum, w_y_sum;
  logic       w_in_view, w_col_last, w_row_last;

  // The press counter sweeps 0..5, so positions 4 and 5 fold back onto lanes 2 and 1.
  always_comb begin
    case (pos_q)
      3'd4:    w_lane = 2'd2;
      3'd5:    w_lane = 2'd1;
      default: w_lane = pos_q[1:0];
    endcase
  end

  assign w_reject   = (pos_q[2] & pos_q[1]) | (~item_q & pos_q[2]);
  assign w_x_sum    = ox_q + {4'd0, col_q};
  assign w_y_sum    = oy_q + {4'd0, row_q};
  assign w_in_view  = (w_x_sum < C_X_LIMIT) && (w_y_sum < C_Y_LIMIT);
  assign w_col_last = (col_q == wm1_q);
  assign w_row_last = (row_q == hm1_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_LOAD;
      S_LOAD:  state_d = w_reject ? S_DONE : S_PLOT;
      S_PLOT:  if (w_col_last && w_row_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      item_q   <= 1'b0;
      erase_q  <= 1'b0;
      fail_q   <= 1'b0;
      pos_q    <= 3'd0;
      ox_q     <= 9'd0;
      oy_q     <= 9'd0;
      wm1_q    <= 5'd0;
      hm1_q    <= 5'd0;
      col_q    <= 5'd0;
      row_q    <= 5'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= req;
          if (req) begin
            item_q  <= item;
            erase_q <= erase;
            pos_q   <= position;
          end
        end
        S_LOAD: begin
          busy_q <= 1'b1;
          fail_q <= w_reject;
          col_q  <= 5'd0;
          row_q  <= 5'd0;
          ox_q   <= 9'(X0 + int'(w_lane) * LANE_PITCH);
          oy_q   <= item_q ? 9'(PRESS_Y) : 9'(GARB_Y);
          wm1_q  <= item_q ? 5'(PRESS_W - 1) : 5'(GARB_W - 1);
          hm1_q  <= item_q ? 5'(PRESS_H - 1) : 5'(GARB_H - 1);
        end
        S_PLOT: begin
          busy_q <= 1'b1;
          plot_q <= w_in_view;
          // Clipped pixels keep x/y/colour frozen; they only consume a cycle.
          if (w_in_view) begin
            x_q      <= w_x_sum[7:0];
            y_q      <= w_y_sum[6:0];
            colour_q <= erase_q ? 3'b000 : (item_q ? 3'b111 : 3'b010);
          end
          if (w_col_last) begin
            col_q <= 5'd0;
            row_q <= row_q + 5'd1;
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
        default: begin
          busy_q <= 1'b1;
          done_q <= 1'b1;
          err_q  <= fail_q;
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_plotter
// Purpose  : Self-checking bench for sprite_plotter against a raster model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_plotter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0, item = 1'b0, erase = 1'b0;
  logic [2:0] position = 3'd0;
  logic [7:0] x, x2;
  logic [6:0] y, y2;
  logic [2:0] colour, colour2;
  logic       plot, busy, done, err, plot2, busy2, done2, err2;

  sprite_plotter dut (
    .clock(clock), .reset(reset), .req(req), .item(item), .erase(erase),
    .position(position), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .err(err)
  );

  // Second instance placed near the screen edge so clipping is exercised.
  sprite_plotter #(.X0(150), .GARB_Y(115)) dut_clip (
    .clock(clock), .reset(reset), .req(req), .item(item), .erase(erase),
    .position(position), .x(x2), .y(y2), .colour(colour2), .plot(plot2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int cap_x[$], cap_y[$], cap_c[$], cap_cyc[$];
  int c2_x[$], c2_y[$], c2_c[$], c2_cyc[$];
  int done_cnt, done_cyc, err_cnt, err_cyc, done2_cyc, busy_c1, busy_early_low;
  int rst_plot, rst_busy;

  int ex_x[$], ex_y[$], ex_cyc[$];
  int ex_col, ex_done, ex_err;

  // Reference raster: every in-view pixel of the sprite in row-major order.
  function automatic void build_model(input int it, input int er, input int pos,
                                      input int x0, input int gy);
    int lane, ox, oy, w, h;
    ex_x.delete(); ex_y.delete(); ex_cyc.delete();
    ex_col = (er != 0) ? 0 : ((it != 0) ? 7 : 2);
    if (pos > 5 || (it == 0 && pos > 3)) begin
      ex_done = 2;
      ex_err  = 1;
      return;
    end
    lane = (pos <= 3) ? pos : 6 - pos;
    ox = x0 + lane * 32;
    oy = (it != 0) ? 40 : gy;
    w  = (it != 0) ? 16 : 12;
    h  = (it != 0) ? 12 : 8;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (ox + c < 160 && oy + r < 120) begin
          ex_x.push_back((ox + c) % 256);
          ex_y.push_back((oy + r) % 128);
          ex_cyc.push_back(2 + r * w + c);
        end
    ex_done = w * h + 2;
    ex_err  = 0;
  endfunction

  // Issue one request at the next edge and record both instances' outputs.
  task automatic capture(input logic it, input logic er, input logic [2:0] pos,
                         input int req2_at, input int rst_at, input int maxcyc);
    cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_cyc.delete();
    c2_x.delete(); c2_y.delete(); c2_c.delete(); c2_cyc.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; done2_cyc = -1;
    busy_c1 = 0; busy_early_low = 0; rst_plot = -1; rst_busy = -1;
    item = it; erase = er; position = pos; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    item = 1'($urandom); erase = 1'($urandom); position = 3'($urandom);
    for (int cyc = 1; cyc <= maxcyc; cyc++) begin
      @(posedge clock); #1;
      if (plot) begin
        cap_x.push_back(int'(x)); cap_y.push_back(int'(y));
        cap_c.push_back(int'(colour)); cap_cyc.push_back(cyc);
      end
      if (plot2) begin
        c2_x.push_back(int'(x2)); c2_y.push_back(int'(y2));
        c2_c.push_back(int'(colour2)); c2_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done2 && done2_cyc < 0) done2_cyc = cyc;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (cyc == 1) busy_c1 = int'(busy);
      if (!busy && done_cyc < 0) busy_early_low = 1;
      if (cyc == rst_at) begin
        rst_plot = int'(plot); rst_busy = int'(busy); reset = 1'b0;
      end
      if (cyc == req2_at) req = 1'b0;
      if (cyc + 1 == req2_at) begin
        req = 1'b1; item = 1'($urandom); erase = 1'($urandom); position = 3'($urandom);
      end
      if (cyc + 1 == rst_at) reset = 1'b1;
      if (done_cyc > 0 && rst_at < 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; item = 1'b1; position = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({x, y, colour, plot, busy, done, err} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {x, y, colour, plot, busy, done, err});
    end
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      n_cmp++;
      if ({busy, plot, done} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_quiet: cycle %0d got busy/plot/done %b expected 000", i, {busy, plot, done});
      end
    end
  endtask

  task automatic test_press_draw();
    int bad_col = 0;
    capture(1'b1, 1'b0, 3'd0, -1, -1, 300);
    n_cmp++;
    if (cap_x.size() != 192) begin
      n_bad++; $display("FAIL press_count: got %0d expected 192", cap_x.size());
    end else begin
      n_cmp++;
      if (cap_x[0] != 20 || cap_y[0] != 40 || cap_cyc[0] != 2) begin
        n_bad++; $display("FAIL press_first: got (%0d,%0d)@%0d expected (20,40)@2", cap_x[0], cap_y[0], cap_cyc[0]);
      end
      n_cmp++;
      if (cap_x[191] != 35 || cap_y[191] != 51 || cap_cyc[191] != 193) begin
        n_bad++; $display("FAIL press_last: got (%0d,%0d)@%0d expected (35,51)@193", cap_x[191], cap_y[191], cap_cyc[191]);
      end
      foreach (cap_c[i]) if (cap_c[i] != 7) bad_col++;
      n_cmp++;
      if (bad_col != 0) begin
        n_bad++; $display("FAIL press_colour: got %0d wrong-colour pixels expected 0", bad_col);
      end
    end
    n_cmp++;
    if (done_cyc != 194 || done_cnt != 1 || err_cnt != 0) begin
      n_bad++; $display("FAIL press_done: got done@%0d x%0d err %0d expected done@194 x1 err 0", done_cyc, done_cnt, err_cnt);
    end
    n_cmp++;
    if (busy_c1 != 1 || busy_early_low != 0) begin
      n_bad++; $display("FAIL press_busy: got c1=%0d early_low=%0d expected 1/0", busy_c1, busy_early_low);
    end
  endtask

  task automatic test_garbage_erase();
    capture(1'b0, 1'b1, 3'd3, -1, -1, 200);
    build_model(0, 1, 3, 20, 90);
    n_cmp++;
    if (cap_x.size() != ex_x.size() || cap_x.size() != 96) begin
      n_bad++; $display("FAIL garb_count: got %0d expected 96", cap_x.size());
    end else begin
      n_cmp++;
      if (cap_x[0] != 116 || cap_y[0] != 90 || cap_x[95] != 127 || cap_y[95] != 97 || cap_c[0] != 0) begin
        n_bad++; $display("FAIL garb_ends: got (%0d,%0d)..(%0d,%0d) c%0d expected (116,90)..(127,97) c0",
                          cap_x[0], cap_y[0], cap_x[95], cap_y[95], cap_c[0]);
      end
    end
    n_cmp++;
    if (done_cyc != 98 || err_cnt != 0) begin
      n_bad++; $display("FAIL garb_done: got done@%0d err %0d expected done@98 err 0", done_cyc, err_cnt);
    end
  endtask

  task automatic test_lane_fold();
    int exp_x0[2] = '{84, 52};
    for (int k = 0; k < 2; k++) begin
      capture(1'b1, 1'b0, 3'(4 + k), -1, -1, 300);
      n_cmp++;
      if (cap_x.size() == 0 || cap_x[0] != exp_x0[k] || cap_y[0] != 40) begin
        n_bad++; $display("FAIL fold_pos%0d: got first x %0d (n=%0d) expected (%0d,40)",
                          4 + k, (cap_x.size() > 0) ? cap_x[0] : -1, cap_x.size(), exp_x0[k]);
      end
    end
  endtask

  task automatic test_rejects();
    logic it_tab[2] = '{1'b1, 1'b0};
    int   ps_tab[2] = '{6, 5};
    for (int k = 0; k < 2; k++) begin
      capture(it_tab[k], 1'b0, 3'(ps_tab[k]), -1, -1, 20);
      n_cmp++;
      if (cap_x.size() != 0 || done_cyc != 2 || err_cyc != 2 || err_cnt != 1 || done_cnt != 1) begin
        n_bad++; $display("FAIL reject_%0d: got plots %0d done@%0d err@%0d expected 0 / 2 / 2",
                          k, cap_x.size(), done_cyc, err_cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    capture(1'b0, 1'b0, 3'd1, -1, -1, 200);
    capture(1'b1, 1'b1, 3'd2, -1, -1, 300);
    n_cmp++;
    if (cap_x.size() != 192 || done_cyc != 194 || cap_c[0] != 0) begin
      n_bad++; $display("FAIL b2b_second: got plots %0d done@%0d expected 192 done@194 colour 0",
                        cap_x.size(), done_cyc);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_busy_fall: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_busy_reset();
    capture(1'b1, 1'b0, 3'd0, 50, -1, 300);
    n_cmp++;
    if (cap_x.size() != 192 || done_cyc != 194 || done_cnt != 1) begin
      n_bad++; $display("FAIL ignore_req: got plots %0d done@%0d expected 192 done@194", cap_x.size(), done_cyc);
    end
    capture(1'b1, 1'b0, 3'd2, -1, 100, 260);
    n_cmp++;
    if (rst_plot != 0 || rst_busy != 0) begin
      n_bad++; $display("FAIL midreset_outs: got plot %0d busy %0d expected 0 0", rst_plot, rst_busy);
    end
    n_cmp++;
    if (done_cnt != 0 || cap_x.size() != 98) begin
      n_bad++; $display("FAIL midreset_abort: got done x%0d plots %0d expected 0 / 98", done_cnt, cap_x.size());
    end
    capture(1'b0, 1'b0, 3'd2, -1, -1, 200);
    build_model(0, 0, 2, 20, 90);
    n_cmp++;
    if (cap_x.size() != ex_x.size() || done_cyc != ex_done || cap_x[0] != ex_x[0]) begin
      n_bad++; $display("FAIL after_reset: got plots %0d done@%0d expected %0d done@%0d",
                        cap_x.size(), done_cyc, ex_x.size(), ex_done);
    end
  endtask

  task automatic test_clipping();
    int it_tab[3] = '{1, 1, 0};
    int ps_tab[3] = '{0, 3, 0};
    int er;
    for (int k = 0; k < 3; k++) begin
      er = int'($urandom_range(0, 1));
      build_model(it_tab[k], er, ps_tab[k], 150, 115);
      capture(1'(it_tab[k]), 1'(er), 3'(ps_tab[k]), -1, -1, 300);
      n_cmp++;
      if (c2_x.size() != ex_x.size() || done2_cyc != ex_done) begin
        n_bad++; $display("FAIL clip_%0d_count: got plots %0d done@%0d expected %0d done@%0d",
                          k, c2_x.size(), done2_cyc, ex_x.size(), ex_done);
      end else begin
        foreach (ex_x[i]) begin
          n_cmp++;
          if (c2_x[i] != ex_x[i] || c2_y[i] != ex_y[i] || c2_c[i] != ex_col || c2_cyc[i] != ex_cyc[i]) begin
            n_bad++; $display("FAIL clip_%0d_px%0d: got (%0d,%0d) c%0d @%0d expected (%0d,%0d) c%0d @%0d",
                              k, i, c2_x[i], c2_y[i], c2_c[i], c2_cyc[i], ex_x[i], ex_y[i], ex_col, ex_cyc[i]);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int it, er, ps;
    for (int k = 0; k < 10; k++) begin
      it = int'($urandom_range(0, 1));
      er = int'($urandom_range(0, 1));
      ps = int'($urandom_range(0, 7));
      build_model(it, er, ps, 20, 90);
      capture(1'(it), 1'(er), 3'(ps), -1, -1, 300);
      n_cmp++;
      if (done_cyc != ex_done || err_cnt != ex_err || done_cnt != 1) begin
        n_bad++; $display("FAIL rand_%0d_done: item %0d pos %0d got done@%0d err %0d expected done@%0d err %0d",
                          k, it, ps, done_cyc, err_cnt, ex_done, ex_err);
      end
      n_cmp++;
      if (cap_x.size() != ex_x.size()) begin
        n_bad++; $display("FAIL rand_%0d_count: got %0d expected %0d", k, cap_x.size(), ex_x.size());
      end else begin
        foreach (ex_x[i]) begin
          n_cmp++;
          if (cap_x[i] != ex_x[i] || cap_y[i] != ex_y[i] || cap_c[i] != ex_col || cap_cyc[i] != ex_cyc[i]) begin
            n_bad++; $display("FAIL rand_%0d_px%0d: got (%0d,%0d) c%0d @%0d expected (%0d,%0d) c%0d @%0d",
                              k, i, cap_x[i], cap_y[i], cap_c[i], cap_cyc[i], ex_x[i], ex_y[i], ex_col, ex_cyc[i]);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_draw();
    test_garbage_erase();
    test_lane_fold();
    test_rejects();
    test_back_to_back();
    test_busy_reset();
    test_clipping();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
